timer_irq_source: RTL and testbench

- Memory-mapped interval timer. It is the requesting end of the processor's external interrupt line.
- It counts up from a reload value and sets a sticky status on overflow. It drives IRQ to the control unit; the control unit gates IRQ with kernel mode.
- The handler acknowledges the interrupt by writing 1 to the status bit. It sits on the data-memory bus beside the data RAM, decoded by address.

---
 rtl/timer_irq_source.sv | 63 ++++++
 tb/tb_timer_irq_source.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_irq_source.sv
// timer_irq_source: memory-mapped interval timer that raises a sticky overflow interrupt
// Ports: clk, reset (synchronous, active-low); Address/MemRead/MemWrite/WriteData from the
// data-memory bus; ReadData combinational load data; IRQ = ST & IE; Hit = Address in window.
module timer_irq_source #(
  parameter logic [31:0] ADDR_BASE = 32'h4000_0000,
  parameter int PRESCALE_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        IRQ,
  output logic        Hit
);
  logic [31:0] th, tl, ovf, off;
  logic [PRESCALE_W-1:0] pre, pc;
  logic en, ie, st, tick, wrap, wr, wr_th, wr_tl, wr_tcon, wr_pre;
  always_comb begin
    // addresses below the base wrap to huge offsets and miss the window
    off = Address - ADDR_BASE;
    Hit = off < 32'h14;
    wr = MemWrite && Hit;
    wr_th = wr && off[4:2] == 3'd0;
    wr_tl = wr && off[4:2] == 3'd1;
    wr_tcon = wr && off[4:2] == 3'd2;
    wr_pre = wr && off[4:2] == 3'd3;
    tick = en && pc == pre;
    // a CPU store to TL overrides the tick, so it also suppresses the overflow
    wrap = tick && tl == '1 && !wr_tl;
    ReadData = !(MemRead && Hit) ? '0 :
               off[4:2] == 3'd0 ? th :
               off[4:2] == 3'd1 ? tl :
               off[4:2] == 3'd2 ? {29'b0, st, ie, en} :
               off[4:2] == 3'd3 ? 32'(pre) : ovf;
  end
  assign IRQ = st & ie;
  always_ff @(posedge clk)
    if (!reset) begin
      th <= '0;
      tl <= '0;
      ovf <= '0;
      pre <= '0;
      pc <= '0;
      en <= 1'b0;
      ie <= 1'b0;
      st <= 1'b0;
    end else begin
      pc <= (wr_tl || wr_pre || tick) ? '0 : pc + PRESCALE_W'(en);
      tl <= wr_tl ? WriteData : !tick ? tl : tl == '1 ? th : tl + 32'd1;
      ovf <= ovf + 32'(wrap);
      // an overflow on the same edge as the acknowledge must not be lost
      st <= wrap ? 1'b1 : (wr_tcon && WriteData[2]) ? 1'b0 : st;
      if (wr_th) th <= WriteData;
      if (wr_pre) pre <= WriteData[PRESCALE_W-1:0];
      if (wr_tcon) begin
        en <= WriteData[0];
        ie <= WriteData[1];
      end
    end
endmodule

// File: tb/tb_timer_irq_source.sv
// tb_timer_irq_source: scenario tasks plus randomized traffic against a behavioural timer model
module tb_timer_irq_source;
  localparam logic [31:0] BASE = 32'h4000_0000;
  logic clk = 0, reset = 0, MemRead = 0, MemWrite = 0;
  logic [31:0] Address = 0, WriteData = 0, ReadData;
  logic IRQ, Hit;
  int errors = 0, checks = 0;
  logic [31:0] m_th, m_tl, m_ovf;
  logic [7:0] m_pre, m_pc;
  logic m_en, m_ie, m_st;

  timer_irq_source #(.ADDR_BASE(BASE), .PRESCALE_W(8)) dut (
    .clk(clk), .reset(reset), .Address(Address), .MemRead(MemRead), .MemWrite(MemWrite),
    .WriteData(WriteData), .ReadData(ReadData), .IRQ(IRQ), .Hit(Hit)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  // One clock edge of the timer, described as ordered rules: prescaler, count/overflow, then bus store.
  task automatic model_edge();
    logic [31:0] o;
    logic w, tick, overflowed;
    if (!reset) begin
      {m_th, m_tl, m_ovf, m_pre, m_pc, m_en, m_ie, m_st} = '0;
      return;
    end
    o = Address - BASE;
    w = MemWrite && o < 20;
    tick = m_en && m_pc == m_pre;
    overflowed = 0;
    if (m_en) m_pc = tick ? 8'd0 : m_pc + 8'd1;
    if (tick && !(w && o / 4 == 1)) begin
      if (m_tl == 32'hFFFF_FFFF) begin
        m_tl = m_th;
        m_st = 1;
        m_ovf = m_ovf + 1;
        overflowed = 1;
      end else m_tl = m_tl + 1;
    end
    if (w) begin
      case (o / 4)
        0: m_th = WriteData;
        1: begin m_tl = WriteData; m_pc = 0; end
        2: begin
          m_en = WriteData[0];
          m_ie = WriteData[1];
          if (WriteData[2] && !overflowed) m_st = 0;
        end
        3: begin m_pre = WriteData[7:0]; m_pc = 0; end
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] addr, input logic rd);
    logic [31:0] o = addr - BASE;
    if (!rd || o >= 20) return 0;
    case (o / 4)
      0: return m_th;
      1: return m_tl;
      2: return {29'b0, m_st, m_ie, m_en};
      3: return {24'b0, m_pre};
      default: return m_ovf;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic store(input logic [31:0] off, input logic [31:0] d);
    Address = BASE + off;
    WriteData = d;
    MemWrite = 1;
    MemRead = 0;
    step();
    MemWrite = 0;
  endtask

  task automatic load(input logic [31:0] off, output logic [31:0] v);
    Address = BASE + off;
    MemRead = 1;
    MemWrite = 0;
    #1;
    v = ReadData;
    MemRead = 0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 0;
    step();
    step();
    reset = 1;
    for (int i = 0; i < 5; i++) begin
      load(i * 4, v);
      checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL reset reg%0d got %h want 0", i, v); end
    end
    checks++;
    if (IRQ !== 1'b0) begin errors++; $display("FAIL reset irq got %b want 0", IRQ); end
  endtask

  task automatic test_basic_overflow();
    logic [31:0] v;
    logic [31:0] exp_tl [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    store(0, 32'hFFFF_FFFC);
    store(4, 32'hFFFF_FFFC);
    store(12, 0);
    store(8, 3);
    for (int k = 0; k < 3; k++) begin
      step();
      load(4, v);
      checks++;
      if (v !== exp_tl[k] || v !== m_tl) begin errors++; $display("FAIL basic tl%0d got %h want %h", k, v, exp_tl[k]); end
    end
    step();
    load(4, v);
    checks++;
    if (v !== 32'hFFFF_FFFC) begin errors++; $display("FAIL basic reload got %h want fffffffc", v); end
    load(8, v);
    checks++;
    if (v !== 32'h7) begin errors++; $display("FAIL basic tcon got %h want 7", v); end
    load(16, v);
    checks++;
    if (v !== 32'h1) begin errors++; $display("FAIL basic ovf got %h want 1", v); end
    checks++;
    if (IRQ !== 1'b1) begin errors++; $display("FAIL basic irq got %b want 1", IRQ); end
  endtask

  task automatic test_ack();
    logic [31:0] v;
    int n = 0;
    store(8, 7);
    checks++;
    if (IRQ !== 1'b0) begin errors++; $display("FAIL ack irq got %b want 0", IRQ); end
    load(8, v);
    checks++;
    if (v !== 32'h3) begin errors++; $display("FAIL ack tcon got %h want 3", v); end
    while (IRQ !== 1'b1 && n < 10) begin step(); n++; end
    checks++;
    if (n != 3) begin errors++; $display("FAIL ack next_overflow cycles got %0d want 3", n); end
    load(16, v);
    checks++;
    if (v !== 32'h2) begin errors++; $display("FAIL ack ovf got %h want 2", v); end
    store(8, 3);
    load(8, v);
    checks++;
    if (v !== 32'h7 || IRQ !== 1'b1) begin errors++; $display("FAIL ack no_w1c tcon got %h irq %b want 7 1", v, IRQ); end
  endtask

  task automatic test_collision();
    logic [31:0] v, o;
    int n = 0;
    while (m_tl != 32'hFFFF_FFFF && n < 8) begin step(); n++; end
    o = m_ovf;
    store(8, 7);
    load(8, v);
    checks++;
    if (v !== 32'h7 || IRQ !== 1'b1) begin errors++; $display("FAIL collision_w1c tcon got %h irq %b want 7 1", v, IRQ); end
    load(16, v);
    checks++;
    if (v !== o + 1) begin errors++; $display("FAIL collision_w1c ovf got %h want %h", v, o + 1); end
    store(8, 7);
    n = 0;
    while (m_tl != 32'hFFFF_FFFF && n < 8) begin step(); n++; end
    o = m_ovf;
    store(4, 32'h10);
    load(4, v);
    checks++;
    if (v !== 32'h10) begin errors++; $display("FAIL collision_tl tl got %h want 10", v); end
    load(16, v);
    checks++;
    if (v !== o || IRQ !== 1'b0) begin errors++; $display("FAIL collision_tl ovf got %h irq %b want %h 0", v, IRQ, o); end
    step();
    load(4, v);
    checks++;
    if (v !== 32'h11) begin errors++; $display("FAIL collision_tl next got %h want 11", v); end
  endtask

  task automatic test_prescale();
    logic [31:0] v;
    store(8, 4);
    store(12, 3);
    store(4, 0);
    store(8, 1);
    for (int c = 1; c <= 12; c++) begin
      step();
      load(4, v);
      checks++;
      if (v !== 32'(c / 4)) begin errors++; $display("FAIL prescale c%0d tl got %h want %h", c, v, c / 4); end
    end
    step();
    step();
    store(12, 3);
    for (int c = 1; c <= 4; c++) begin
      step();
      load(4, v);
      checks++;
      if (v !== (c == 4 ? 32'd4 : 32'd3)) begin errors++; $display("FAIL prescale_restart c%0d tl got %h", c, v); end
    end
    step();
    store(8, 0);
    repeat (10) step();
    load(4, v);
    checks++;
    if (v !== 32'd4) begin errors++; $display("FAIL prescale_freeze tl got %h want 4", v); end
    store(8, 1);
    step();
    load(4, v);
    checks++;
    if (v !== 32'd4) begin errors++; $display("FAIL prescale_resume1 tl got %h want 4", v); end
    step();
    load(4, v);
    checks++;
    if (v !== 32'd5) begin errors++; $display("FAIL prescale_resume2 tl got %h want 5", v); end
  endtask

  task automatic test_decode();
    logic [31:0] v, o;
    load(20, v);
    checks++;
    if (v !== 0 || Hit !== 1'b0) begin errors++; $display("FAIL decode_past got %h hit %b want 0 0", v, Hit); end
    load(-4, v);
    checks++;
    if (v !== 0 || Hit !== 1'b0) begin errors++; $display("FAIL decode_below got %h hit %b want 0 0", v, Hit); end
    load(19, v);
    checks++;
    if (v !== m_ovf || Hit !== 1'b1) begin errors++; $display("FAIL decode_top got %h hit %b want %h 1", v, Hit, m_ovf); end
    store(0, 32'hA5A5_1234);
    Address = BASE;
    #1;
    checks++;
    if (ReadData !== 0 || Hit !== 1'b1) begin errors++; $display("FAIL decode_noread got %h hit %b want 0 1", ReadData, Hit); end
    o = m_ovf;
    store(16, 32'hDEAD);
    load(16, v);
    checks++;
    if (v !== o) begin errors++; $display("FAIL decode_ovf_ro got %h want %h", v, o); end
    store(12, 32'hFFFF_FF05);
    load(12, v);
    checks++;
    if (v !== 32'h5) begin errors++; $display("FAIL decode_pre got %h want 5", v); end
    store(8, 32'hFFFF_FFF8);
    load(8, v);
    checks++;
    if (v !== m_read(BASE + 8, 1) || v[31:3] !== 0) begin errors++; $display("FAIL decode_tcon got %h want %h", v, m_read(BASE + 8, 1)); end
  endtask

  task automatic test_ie_late();
    logic [31:0] v;
    int n = 0;
    store(8, 4);
    store(12, 0);
    store(0, 32'hFFFF_FFFE);
    store(4, 32'hFFFF_FFFE);
    store(8, 1);
    while (!m_st && n < 5) begin step(); n++; end
    load(8, v);
    checks++;
    if (v !== 32'h5 || IRQ !== 1'b0) begin errors++; $display("FAIL ie_late masked tcon got %h irq %b want 5 0", v, IRQ); end
    store(8, 3);
    checks++;
    if (IRQ !== 1'b1) begin errors++; $display("FAIL ie_late irq got %b want 1", IRQ); end
  endtask

  task automatic test_reset_midcount();
    logic [31:0] v;
    reset = 0;
    step();
    checks++;
    if (IRQ !== 1'b0) begin errors++; $display("FAIL reset_mid irq got %b want 0", IRQ); end
    load(4, v);
    checks++;
    if (v !== 0) begin errors++; $display("FAIL reset_mid tl got %h want 0", v); end
    step();
    reset = 1;
    for (int i = 0; i < 5; i++) begin
      load(i * 4, v);
      checks++;
      if (v !== 0) begin errors++; $display("FAIL reset_mid reg%0d got %h want 0", i, v); end
    end
    repeat (3) step();
    load(4, v);
    checks++;
    if (v !== 0 || IRQ !== 1'b0) begin errors++; $display("FAIL reset_mid idle tl got %h irq %b want 0 0", v, IRQ); end
  endtask

  task automatic test_random();
    logic [31:0] off, d;
    logic w;
    for (int it = 0; it < 400; it++) begin
      reset = $urandom_range(0, 99) >= 2;
      off = $urandom_range(0, 99) < 5 ? $urandom : ($urandom_range(0, 5) * 4 + $urandom_range(0, 3));
      w = $urandom_range(0, 3) == 0;
      case (off[4:2])
        3'd0, 3'd1: d = 32'hFFFF_FFF0 | $urandom_range(0, 15);
        3'd2: d = $urandom_range(0, 7) | ($urandom_range(0, 3) != 0 ? 32'd1 : 32'd0);
        3'd3: d = $urandom_range(0, 2);
        default: d = $urandom;
      endcase
      Address = BASE + off;
      WriteData = d;
      MemWrite = w;
      MemRead = !w && $urandom_range(0, 3) != 0;
      #1;
      checks++;
      if (ReadData !== m_read(Address, MemRead) || Hit !== (Address - BASE < 20) || IRQ !== (m_st & m_ie)) begin
        errors++;
        $display("FAIL random it%0d addr %h rd %h hit %b irq %b want %h %b %b", it, Address, ReadData, Hit, IRQ,
                 m_read(Address, MemRead), Address - BASE < 20, m_st & m_ie);
      end
      step();
      MemWrite = 0;
      MemRead = 0;
    end
    reset = 1;
  endtask

  initial begin
    test_reset();
    test_basic_overflow();
    test_ack();
    test_collision();
    test_prescale();
    test_decode();
    test_ie_late();
    test_reset_midcount();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
